// File: rtl/mac_tx_framer.sv
// mac_tx_framer: byte-wide Ethernet TX framer (preamble, SFD, payload, FCS, inter-frame gap).
// Define MAC_TX_PAD_EN to zero-pad short frames up to MIN_LEN bytes before the FCS.
module mac_tx_framer #(
  parameter int PREAMBLE_LEN = 7,
  parameter int IFG_CYCLES   = 12,
  parameter int MAX_LEN      = 1514
`ifdef MAC_TX_PAD_EN
  ,
  parameter int MIN_LEN      = 60
`endif
) (
  input  logic       mac_tx_clk,
  input  logic       rst,
  input  logic [7:0] mac_tx_data,
  input  logic       mac_tx_valid,
  input  logic       mac_tx_sof,
  input  logic       mac_tx_eof,
  output logic       mac_tx_ready,
  output logic [7:0] gmii_txd,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic       tx_busy_o,
  output logic       tx_done_o,
  output logic       tx_err_o
);

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    SFD,
    DATA,
`ifdef MAC_TX_PAD_EN
    PAD,
`endif
    FCS,
    IFG,
    DRAIN
  } state_t;

  localparam logic [7:0]  PRE_LAST  = 8'(PREAMBLE_LEN - 1);
  localparam logic [7:0]  IFG_LOAD  = 8'(IFG_CYCLES - 1);
  // An abort carrying eof enters IFG while the abort marker is still on the wire.
  localparam logic [7:0]  IFG_ABORT = 8'(IFG_CYCLES);
  localparam logic [10:0] MAX_CNT   = 11'(MAX_LEN);
`ifdef MAC_TX_PAD_EN
  localparam logic [10:0] MIN_CNT   = 11'(MIN_LEN);
`endif

  state_t      state, state_n;
  logic [7:0]  step, step_n;
  logic [10:0] byte_cnt, cnt_n, cnt_inc;
  logic [31:0] crc, crc_n, fcs;
  logic [7:0]  txd_n, fcs_sel;
  logic        en_n, er_n, done_n, err_n, start;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  assign mac_tx_ready = (state == SFD) || (state == DATA) || (state == DRAIN);
  assign start        = mac_tx_valid & mac_tx_sof;
  assign cnt_inc      = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;
  assign fcs          = ~crc;
  assign fcs_sel      = fcs[{step[1:0], 3'b000} +: 8];

  // In FCS, step is the index of the next FCS byte; step 0 means the last payload byte is showing.
  always_comb begin
    state_n = state;
    step_n  = step;
    cnt_n   = byte_cnt;
    crc_n   = crc;
    txd_n   = 8'h00;
    en_n    = 1'b0;
    er_n    = 1'b0;
    done_n  = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = PRE;
          step_n  = '0;
          cnt_n   = '0;
          crc_n   = '1;
          txd_n   = 8'h55;
          en_n    = 1'b1;
        end
      end
      PRE: begin
        en_n = 1'b1;
        if (step == PRE_LAST) begin
          state_n = SFD;
          txd_n   = 8'hD5;
        end else begin
          step_n = step + 8'd1;
          txd_n  = 8'h55;
        end
      end
      SFD, DATA: begin
        en_n = 1'b1;
        if (!mac_tx_valid) begin
          state_n = DRAIN;
          er_n    = 1'b1;
          err_n   = 1'b1;
        end else if (byte_cnt == MAX_CNT) begin
          state_n = mac_tx_eof ? IFG : DRAIN;
          step_n  = IFG_ABORT;
          cnt_n   = cnt_inc;
          er_n    = 1'b1;
          err_n   = 1'b1;
        end else begin
          txd_n = mac_tx_data;
          cnt_n = cnt_inc;
          crc_n = crc_byte(crc, mac_tx_data);
          if (mac_tx_eof) begin
            step_n = '0;
`ifdef MAC_TX_PAD_EN
            state_n = (cnt_inc < MIN_CNT) ? PAD : FCS;
`else
            state_n = FCS;
`endif
          end else begin
            state_n = DATA;
          end
        end
      end
`ifdef MAC_TX_PAD_EN
      PAD: begin
        en_n = 1'b1;
        if (byte_cnt < MIN_CNT) begin
          crc_n = crc_byte(crc, 8'h00);
          cnt_n = cnt_inc;
        end else begin
          state_n = FCS;
          txd_n   = fcs[7:0];
          step_n  = 8'd1;
        end
      end
`endif
      FCS: begin
        if (step == 8'd4) begin
          state_n = IFG;
          step_n  = IFG_LOAD;
          done_n  = 1'b1;
        end else begin
          txd_n  = fcs_sel;
          en_n   = 1'b1;
          step_n = step + 8'd1;
        end
      end
      IFG: begin
        if (step != '0) begin
          step_n = step - 8'd1;
        end else if (start) begin
          state_n = PRE;
          step_n  = '0;
          cnt_n   = '0;
          crc_n   = '1;
          txd_n   = 8'h55;
          en_n    = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      DRAIN: begin
        if (mac_tx_valid && mac_tx_eof) begin
          state_n = IFG;
          step_n  = IFG_LOAD;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge mac_tx_clk) begin
    if (rst) begin
      state      <= IDLE;
      step       <= '0;
      byte_cnt   <= '0;
      crc        <= 32'hFFFFFFFF;
      gmii_txd   <= 8'h00;
      gmii_tx_en <= 1'b0;
      gmii_tx_er <= 1'b0;
      tx_busy_o  <= 1'b0;
      tx_done_o  <= 1'b0;
      tx_err_o   <= 1'b0;
    end else begin
      state      <= state_n;
      step       <= step_n;
      byte_cnt   <= cnt_n;
      crc        <= crc_n;
      gmii_txd   <= txd_n;
      gmii_tx_en <= en_n;
      gmii_tx_er <= er_n;
      tx_busy_o  <= (state_n != IDLE);
      tx_done_o  <= done_n;
      tx_err_o   <= err_n;
    end
  end

endmodule

// File: tb/tb_mac_tx_framer.sv
// tb_mac_tx_framer: scoreboard bench for mac_tx_framer; a frame-level model fills the expected
// wire/event queues while a negedge monitor pops and compares whatever the DUT puts on the wire.
module tb_mac_tx_framer;

  localparam int PRE_N = 7;
  localparam int IFG_N = 12;
  localparam int MIN_N = 60;

  typedef logic [7:0] bytes_t[$];

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] mac_tx_data;
  logic       mac_tx_valid, mac_tx_sof, mac_tx_eof;
  logic       mac_tx_ready;
  logic [7:0] gmii_txd;
  logic       gmii_tx_en, gmii_tx_er, tx_busy_o, tx_done_o, tx_err_o;

  logic [8:0]  exp_q[$];
  logic        ev_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          gap_cnt = 1000;
  int          last_gap = 0;
  logic        prev_en = 1'b0;
  logic [31:0] last4 = '0;
  logic [8:0]  mon_e;
  logic        mon_ev;
  bytes_t      f, g;
  int          gap_at, len;

  mac_tx_framer dut (
    .mac_tx_clk  (clk),
    .rst         (rst),
    .mac_tx_data (mac_tx_data),
    .mac_tx_valid(mac_tx_valid),
    .mac_tx_sof  (mac_tx_sof),
    .mac_tx_eof  (mac_tx_eof),
    .mac_tx_ready(mac_tx_ready),
    .gmii_txd    (gmii_txd),
    .gmii_tx_en  (gmii_tx_en),
    .gmii_tx_er  (gmii_tx_er),
    .tx_busy_o   (tx_busy_o),
    .tx_done_o   (tx_done_o),
    .tx_err_o    (tx_err_o)
  );

  always #4 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  // Bit-serial CRC-32 over the whole frame, LSB of each byte first.
  function automatic logic [31:0] ref_crc(input bytes_t fr);
    logic [31:0] c;
    logic        fb;
    c = '1;
    foreach (fr[i])
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ fr[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    return c;
  endfunction

  function automatic bytes_t rand_frame(input int n);
    bytes_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
    return q;
  endfunction

  // cut < 0: complete frame. cut >= 0: only cut payload bytes, then abort marker (is_err) or nothing.
  task automatic expect_frame(input bytes_t pl, input int cut, input bit is_err);
    bytes_t      fr;
    logic [31:0] c;
    repeat (PRE_N) exp_q.push_back({1'b0, 8'h55});
    exp_q.push_back({1'b0, 8'hD5});
    if (cut >= 0) begin
      for (int i = 0; i < cut; i++) exp_q.push_back({1'b0, pl[i]});
      if (is_err) begin
        exp_q.push_back(9'h100);
        ev_q.push_back(1'b0);
      end
    end else begin
      fr = pl;
`ifdef MAC_TX_PAD_EN
      while (fr.size() < MIN_N) fr.push_back(8'h00);
`endif
      foreach (fr[i]) exp_q.push_back({1'b0, fr[i]});
      c = ~ref_crc(fr);
      for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, c[8*k +: 8]});
      ev_q.push_back(1'b1);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      gap_cnt = 1000;
    end else begin
      if (gmii_tx_en && !prev_en) begin
        last_gap = gap_cnt;
        checkOutput("ifg_min", 32'(gap_cnt >= IFG_N), 32'd1);
      end
      if (gmii_tx_en) begin
        last4 = {gmii_txd, last4[31:8]};
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL unexpected_byte: got txd=%h er=%b on wire, want idle", gmii_txd, gmii_tx_er);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("wire_byte", {tx_busy_o, gmii_tx_er, gmii_txd}, {1'b1, mon_e});
        end
      end else if (gmii_tx_er) begin
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL tx_er_idle: got tx_er=1 with tx_en=0, want tx_er=0");
      end
      if (tx_done_o || tx_err_o) begin
        if (ev_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL unexpected_pulse: got done=%b err=%b, want no pulse", tx_done_o, tx_err_o);
        end else begin
          mon_ev = ev_q.pop_front();
          checkOutput(mon_ev ? "done_pulse" : "err_pulse",
                      {tx_done_o, tx_err_o, gmii_tx_en, gmii_tx_er, prev_en},
                      mon_ev ? 32'b10001 : 32'b01111);
        end
      end
      gap_cnt = gmii_tx_en ? 0 : gap_cnt + 1;
    end
    prev_en = gmii_tx_en;
  end

  // Sends one frame; gap_at drops valid for one cycle before that byte, rst_at resets after that byte.
  task automatic applyStimulus(input bytes_t pl, input int gap_at_i, input int rst_at);
    for (int i = 0; i < pl.size(); i++) begin
      int   t;
      logic ok;
      @(negedge clk);
      if (i == gap_at_i) begin
        mac_tx_valid = 1'b0;
        @(negedge clk);
      end
      mac_tx_data  = pl[i];
      mac_tx_valid = 1'b1;
      mac_tx_sof   = (i == 0);
      mac_tx_eof   = (i == pl.size() - 1);
      t = 0;
      forever begin
        ok = mac_tx_ready;
        @(posedge clk);
        if (ok) break;
        t++;
        if (t > 400) break;
        @(negedge clk);
      end
      if (!ok) begin
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL accept_timeout: got byte %0d not accepted in 400 cycles, want accepted", i);
        mac_tx_valid = 1'b0;
        return;
      end
      if (i + 1 == rst_at) begin
        @(negedge clk);
        #1 rst = 1'b1;
        mac_tx_valid = 1'b0;
        @(negedge clk);
        checkOutput("tx_en_after_rst", {gmii_tx_en, tx_busy_o}, 32'd0);
        #1 rst = 1'b0;
        return;
      end
    end
  endtask

  task automatic idle(input int n, input bit junk);
    repeat (n) begin
      @(negedge clk);
      mac_tx_valid = junk && ($urandom_range(0, 1) == 1);
      mac_tx_sof   = 1'b0;
      mac_tx_eof   = 1'b0;
      mac_tx_data  = 8'($urandom_range(0, 255));
    end
    @(negedge clk);
    mac_tx_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || ev_q.size() != 0) && t < 3000) begin
      @(posedge clk);
      t++;
    end
    @(negedge clk);
    checkOutput("drain_pending", 32'(exp_q.size() + ev_q.size()), 32'd0);
    exp_q.delete();
    ev_q.delete();
  endtask

  initial begin
    #(8 * 90000);
    $display("[TB] FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    mac_tx_valid = 1'b0;
    mac_tx_sof = 1'b0;
    mac_tx_eof = 1'b0;
    mac_tx_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_txd", 32'(gmii_txd), 32'd0);
    checkOutput("rst_tx_en", 32'(gmii_tx_en), 32'd0);
    checkOutput("rst_tx_er", 32'(gmii_tx_er), 32'd0);
    checkOutput("rst_busy", 32'(tx_busy_o), 32'd0);
    checkOutput("rst_pulses", {tx_done_o, tx_err_o}, 32'd0);
    checkOutput("rst_ready", 32'(mac_tx_ready), 32'd0);
    #1 rst = 1'b0;

    // Valid without sof while idle must not start a frame.
    @(negedge clk);
    mac_tx_valid = 1'b1;
    mac_tx_data  = 8'hAB;
    repeat (5) @(negedge clk);
    checkOutput("idle_ignore", {gmii_tx_en, tx_busy_o, mac_tx_ready}, 32'd0);
    mac_tx_valid = 1'b0;

    f = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    expect_frame(f, -1, 1'b0);
    applyStimulus(f, -1, 0);
    idle(2, 1'b0);
    wait_drain();
`ifndef MAC_TX_PAD_EN
    checkOutput("fcs_123456789", last4, 32'hCBF43926);
`endif

    f = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h08, 8'h00};
    expect_frame(f, -1, 1'b0);
    applyStimulus(f, -1, 0);
    idle(2, 1'b0);
    wait_drain();

    f = rand_frame(60);
    g = rand_frame(60);
    expect_frame(f, -1, 1'b0);
    applyStimulus(f, -1, 0);
    expect_frame(g, -1, 1'b0);
    applyStimulus(g, -1, 0);
    checkOutput("b2b_gap", 32'(last_gap), 32'(IFG_N));
    idle(2, 1'b0);
    wait_drain();

    f = rand_frame(60);
    expect_frame(f, 20, 1'b1);
    applyStimulus(f, 20, 0);
    idle(2, 1'b0);
    wait_drain();

    f = rand_frame(1514);
    expect_frame(f, -1, 1'b0);
    applyStimulus(f, -1, 0);
    idle(2, 1'b0);
    wait_drain();

    f = rand_frame(1520);
    expect_frame(f, 1514, 1'b1);
    applyStimulus(f, -1, 0);
    idle(2, 1'b0);
    wait_drain();

    f = rand_frame(60);
    expect_frame(f, 30, 1'b0);
    applyStimulus(f, -1, 30);
    checkOutput("rst_flush", 32'(exp_q.size() + ev_q.size()), 32'd0);
    g = rand_frame(40);
    expect_frame(g, -1, 1'b0);
    applyStimulus(g, -1, 0);
    idle(2, 1'b0);
    wait_drain();

    for (int n = 0; n < 25; n++) begin
      len = $urandom_range(1, 100);
      f = rand_frame(len);
      gap_at = -1;
      if (len >= 2 && $urandom_range(0, 4) == 0) begin
        gap_at = $urandom_range(1, len - 1);
        expect_frame(f, gap_at, 1'b1);
      end else begin
        expect_frame(f, -1, 1'b0);
      end
      applyStimulus(f, gap_at, 0);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 20), 1'b1);
    end
    idle(2, 1'b0);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
